// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: steps one stage per clock,
// owns PC, status code and the data-memory handshake. Define SEQ_PERF_CNT_EN for perf counters.
module y86_seq_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int RESET_PC    = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              hlt,
  input  logic [ADDR_W-1:0] updated_pc,
  input  logic              dmem_ready,
  input  logic              dmem_error,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pc_en,
  output logic              dmem_req,
  output logic [2:0]        stat,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    MEMORY    = 4'd4,
    MEM_WAIT  = 4'd5,
    WRITEBACK = 4'd6,
    PCUPD     = 4'd7,
    HALTED    = 4'd8
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [2:0]        stat_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_icode;

  assign mem_icode = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                     (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

  // In MEMORY the registered dmem_req already tells whether this is a memory op
  always_comb begin
    state_n = state;
    stat_n  = stat;
    case (state)
      IDLE:    if (run) state_n = FETCH;
      FETCH: begin
        if (imem_error) begin
          stat_n  = STAT_ADR;
          state_n = HALTED;
        end else if (!instr_valid) begin
          stat_n  = STAT_INS;
          state_n = HALTED;
        end else if (hlt) begin
          stat_n  = STAT_HLT;
          state_n = HALTED;
        end else begin
          state_n = DECODE;
        end
      end
      DECODE:  state_n = EXECUTE;
      EXECUTE: state_n = MEMORY;
      MEMORY, MEM_WAIT: begin
        if (!dmem_req) begin
          state_n = WRITEBACK;
        end else if (dmem_ready) begin
          if (dmem_error) begin
            stat_n  = STAT_ADR;
            state_n = HALTED;
          end else begin
            state_n = WRITEBACK;
          end
        end else if (state == MEM_WAIT && wait_cnt == WAIT_LAST) begin
          stat_n  = STAT_ADR;
          state_n = HALTED;
        end else begin
          state_n = MEM_WAIT;
        end
      end
      WRITEBACK: state_n = PCUPD;
      PCUPD:     state_n = run ? FETCH : IDLE;
      HALTED:    state_n = HALTED;
      default:   state_n = IDLE;
    endcase
  end

  // Strobes and handshake are registered from the next state so outputs never see inputs combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      PC        <= ADDR_W'(RESET_PC);
      stat      <= STAT_AOK;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      pc_en     <= 1'b0;
      dmem_req  <= 1'b0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      stat      <= stat_n;
      fetch_en  <= (state_n == FETCH);
      decode_en <= (state_n == DECODE);
      exec_en   <= (state_n == EXECUTE);
      mem_en    <= (state_n == MEMORY) || (state_n == MEM_WAIT);
      wb_en     <= (state_n == WRITEBACK);
      pc_en     <= (state_n == PCUPD);
      dmem_req  <= ((state_n == MEMORY) && mem_icode) || (state_n == MEM_WAIT);
      busy      <= (state_n != IDLE) && (state_n != HALTED);
      if (state == MEM_WAIT && state_n == MEM_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state == PCUPD)
        PC <= updated_pc;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy && cycle_q != '1)
        cycle_q <= cycle_q + CNT_W'(1);
      if (state == PCUPD && instr_q != '1)
        instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
